// File: rtl/sap1_pkg.sv
// ============================================================================
// sap1_pkg : opcode encoding, control-word bit map and fetch/execute words.
// Rev 1.0
// ============================================================================
`default_nettype none

package sap1_pkg;

   localparam int OPC_W = 4;
   localparam int CON_W = 12;
   localparam int NT    = 6;

   typedef logic [CON_W-1:0] con_t;
   typedef logic [NT-1:0]    ring_t;

   typedef enum logic [OPC_W-1:0] {
      OP_LDA = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   // Bit positions in CON, MSB first: {CP,EP,LM_BAR,CE_BAR,LI_BAR,EI_BAR,LA_BAR,EA,SU,EU,LB_BAR,LO_BAR}
   localparam int CON_CP     = 11;
   localparam int CON_EP     = 10;
   localparam int CON_LM_BAR = 9;
   localparam int CON_CE_BAR = 8;
   localparam int CON_LI_BAR = 7;
   localparam int CON_EI_BAR = 6;
   localparam int CON_LA_BAR = 5;
   localparam int CON_EA     = 4;
   localparam int CON_SU     = 3;
   localparam int CON_EU     = 2;
   localparam int CON_LB_BAR = 1;
   localparam int CON_LO_BAR = 0;

   localparam con_t B_CP     = con_t'(1) << CON_CP;
   localparam con_t B_EP     = con_t'(1) << CON_EP;
   localparam con_t B_LM_BAR = con_t'(1) << CON_LM_BAR;
   localparam con_t B_CE_BAR = con_t'(1) << CON_CE_BAR;
   localparam con_t B_LI_BAR = con_t'(1) << CON_LI_BAR;
   localparam con_t B_EI_BAR = con_t'(1) << CON_EI_BAR;
   localparam con_t B_LA_BAR = con_t'(1) << CON_LA_BAR;
   localparam con_t B_EA     = con_t'(1) << CON_EA;
   localparam con_t B_SU     = con_t'(1) << CON_SU;
   localparam con_t B_EU     = con_t'(1) << CON_EU;
   localparam con_t B_LB_BAR = con_t'(1) << CON_LB_BAR;
   localparam con_t B_LO_BAR = con_t'(1) << CON_LO_BAR;

   // Every active-low strobe deasserted, every active-high strobe off (0x3E3).
   localparam con_t CW_IDLE = B_LM_BAR | B_CE_BAR | B_LI_BAR | B_EI_BAR |
                              B_LA_BAR | B_LB_BAR | B_LO_BAR;

   localparam con_t CW_T1 = (CW_IDLE | B_EP) & ~B_LM_BAR;
   localparam con_t CW_T2 = CW_IDLE | B_CP;
   localparam con_t CW_T3 = CW_IDLE & ~B_CE_BAR & ~B_LI_BAR;

   localparam con_t CW_LDA_T4 = CW_IDLE & ~B_LM_BAR & ~B_EI_BAR;
   localparam con_t CW_LDA_T5 = CW_IDLE & ~B_CE_BAR & ~B_LA_BAR;
   localparam con_t CW_ADD_T4 = CW_LDA_T4;
   localparam con_t CW_ADD_T5 = CW_IDLE & ~B_CE_BAR & ~B_LB_BAR;
   localparam con_t CW_ADD_T6 = (CW_IDLE & ~B_LA_BAR) | B_EU;
   localparam con_t CW_SUB_T6 = CW_ADD_T6 | B_SU;
   localparam con_t CW_OUT_T4 = (CW_IDLE | B_EA) & ~B_LO_BAR;

   localparam ring_t RING_T1 = 6'b000001;
   localparam ring_t RING_T2 = 6'b000010;
   localparam ring_t RING_T3 = 6'b000100;
   localparam ring_t RING_T4 = 6'b001000;
   localparam ring_t RING_T5 = 6'b010000;
   localparam ring_t RING_T6 = 6'b100000;

   function automatic logic is_onehot(input ring_t v);
      return (v != '0) && ((v & (v - ring_t'(1))) == '0);
   endfunction

   // phase 0/1/2 selects T4/T5/T6; unknown opcodes behave as NOP.
   function automatic con_t exec_word(input logic [OPC_W-1:0] op,
                                      input logic [1:0]       phase);
      con_t w;
      w = CW_IDLE;
      case (op)
         OP_LDA: begin
            if (phase == 2'd0)      w = CW_LDA_T4;
            else if (phase == 2'd1) w = CW_LDA_T5;
         end
         OP_ADD: begin
            if (phase == 2'd0)      w = CW_ADD_T4;
            else if (phase == 2'd1) w = CW_ADD_T5;
            else if (phase == 2'd2) w = CW_ADD_T6;
         end
         OP_SUB: begin
            if (phase == 2'd0)      w = CW_ADD_T4;
            else if (phase == 2'd1) w = CW_ADD_T5;
            else if (phase == 2'd2) w = CW_SUB_T6;
         end
         OP_OUT: begin
            if (phase == 2'd0)      w = CW_OUT_T4;
         end
         default: w = CW_IDLE;
      endcase
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ring_counter_6.sv
// ============================================================================
// ring_counter_6 : one-hot T1..T6 ring, advances on the falling clock edge.
// Rev 1.0
// ============================================================================
`default_nettype none

module ring_counter_6
   import sap1_pkg::*;
(
   input  logic          CLK,
   input  logic          CLR,
   input  logic          HOLD,
   output logic [NT-1:0] T
);

   ring_t r_t;

   // A corrupted (non one-hot) ring recovers to T1 even while held.
   always_ff @(negedge CLK or posedge CLR) begin
      if (CLR) begin
         r_t <= RING_T1;
      end else if (!is_onehot(r_t)) begin
         r_t <= RING_T1;
      end else if (!HOLD) begin
         r_t <= {r_t[NT-2:0], r_t[NT-1]};
      end
   end

   assign T = r_t;

endmodule

`default_nettype wire

// File: rtl/sap1_ctrl_seq.sv
// ============================================================================
// sap1_ctrl_seq : SAP-1 controller-sequencer (ring counter, halt latch, decoder).
// Rev 1.0
// ============================================================================
`default_nettype none

module sap1_ctrl_seq
   import sap1_pkg::*;
(
   input  logic             CLK,
   input  logic             CLR,
   input  logic [OPC_W-1:0] OPCODE,
   output logic [NT-1:0]    T,
   output logic [CON_W-1:0] CON,
   output logic             HLT
);

   ring_t w_t;
   con_t  w_con;
   logic  r_halted;

   ring_counter_6 u_ring (
      .CLK  (CLK),
      .CLR  (CLR),
      .HOLD (r_halted),
      .T    (w_t)
   );

   // The T3->T4 edge is the only point where HLT is sampled.
   always_ff @(negedge CLK or posedge CLR) begin
      if (CLR) begin
         r_halted <= 1'b0;
      end else if ((w_t == RING_T3) && (OPCODE == OP_HLT)) begin
         r_halted <= 1'b1;
      end
   end

   always_comb begin
      w_con = CW_IDLE;
      if (!r_halted) begin
         case (w_t)
            RING_T1: w_con = CW_T1;
            RING_T2: w_con = CW_T2;
            RING_T3: w_con = CW_T3;
            RING_T4: w_con = exec_word(OPCODE, 2'd0);
            RING_T5: w_con = exec_word(OPCODE, 2'd1);
            RING_T6: w_con = exec_word(OPCODE, 2'd2);
            default: w_con = CW_IDLE;
         endcase
      end
   end

   assign T   = w_t;
   assign CON = w_con;
   assign HLT = r_halted;

endmodule

`default_nettype wire
